// File: rtl/ysyx_22041412_wbu_pkg.sv
// Shared definitions for the write-back unit: datapath/register widths,
// load funct3 encodings and the load tag layout held in the load queue.
package ysyx_22041412_wbu_pkg;

  localparam int WBU_XLEN = 64;
  localparam int REG_AW   = 5;
  localparam int LDQ_W    = REG_AW + 3;

  typedef enum logic [2:0] {
    LB   = 3'b000,
    LH   = 3'b001,
    LW   = 3'b010,
    LD   = 3'b011,
    LBU  = 3'b100,
    LHU  = 3'b101,
    LWU  = 3'b110,
    LNOP = 3'b111
  } ld_funct3_e;

endpackage

// File: rtl/ysyx_22041412_ld_fifo.sv
// In-order queue of outstanding load tags {rd, funct3}; head is read
// combinationally so the response can be written back in the same cycle.
module ysyx_22041412_ld_fifo
  import ysyx_22041412_wbu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [LDQ_W-1:0] wdata,
  output logic [LDQ_W-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [LDQ_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ysyx_22041412_wbu.sv
// Write-back unit: arbitrates load responses and EXU results onto the single
// register-file write port, tracks in-flight load destinations for hazards.
module ysyx_22041412_wbu
  import ysyx_22041412_wbu_pkg::*;
#(
  parameter int XLEN     = WBU_XLEN,
  parameter int LD_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic              exu_wen,
  input  logic [REG_AW-1:0] exu_rd,
  input  logic [XLEN-1:0]   exu_data,
  input  logic              ld_issue,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [2:0]        ld_funct3,
  input  logic              lsu_rvalid,
  input  logic [XLEN-1:0]   lsu_rdata,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  output logic              dec_stall,
  output logic              byp_a_en,
  output logic              byp_b_en,
  output logic              resp_err,
  output logic [REG_AW-1:0] Rw,
  output logic              Wen,
  output logic [XLEN-1:0]   BusW
);

  logic              fifo_full, fifo_empty;
  logic [LDQ_W-1:0]  head_tag;
  logic [REG_AW-1:0] head_rd;
  logic [2:0]        head_f3;
  logic              ld_push, ld_pop, exu_fire;
  logic [XLEN-1:0]   ld_ext;

  logic [REG_AW-1:0] rw_q, rw_d;
  logic              wen_q, wen_d;
  logic [XLEN-1:0]   busw_q, busw_d;
  logic [31:0]       busy_q, busy_d;
  logic              resp_err_q, resp_err_d;

  ysyx_22041412_ld_fifo #(.DEPTH(LD_DEPTH)) u_ld_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ld_push),
    .pop   (ld_pop),
    .wdata ({ld_rd, ld_funct3}),
    .rdata (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_rd, head_f3} = head_tag;
  assign ld_pop    = lsu_rvalid & ~fifo_empty;
  assign ld_push   = ld_issue & ~fifo_full;
  assign ld_ready  = ~fifo_full;
  assign exu_ready = ~ld_pop;
  assign exu_fire  = exu_valid & exu_ready;

  always_comb begin
    ld_ext = '0;
    case (head_f3)
      LB:      ld_ext = {{(XLEN-8){lsu_rdata[7]}},   lsu_rdata[7:0]};
      LH:      ld_ext = {{(XLEN-16){lsu_rdata[15]}}, lsu_rdata[15:0]};
      LW:      ld_ext = {{(XLEN-32){lsu_rdata[31]}}, lsu_rdata[31:0]};
      LD:      ld_ext = lsu_rdata;
      LBU:     ld_ext = {{(XLEN-8){1'b0}},  lsu_rdata[7:0]};
      LHU:     ld_ext = {{(XLEN-16){1'b0}}, lsu_rdata[15:0]};
      LWU:     ld_ext = {{(XLEN-32){1'b0}}, lsu_rdata[31:0]};
      default: ld_ext = '0;
    endcase
  end

  // Load responses win the port; an idle cycle keeps the last address/data.
  always_comb begin
    rw_d   = rw_q;
    busw_d = busw_q;
    wen_d  = 1'b0;
    if (ld_pop) begin
      rw_d   = head_rd;
      busw_d = ld_ext;
      wen_d  = |head_rd;
    end else if (exu_fire) begin
      rw_d   = exu_rd;
      busw_d = exu_data;
      wen_d  = exu_wen & (|exu_rd);
    end
  end

  // Set is applied after clear so a re-issued load to the same rd stays busy.
  always_comb begin
    busy_d = busy_q;
    if (ld_pop) busy_d[head_rd] = 1'b0;
    if (ld_push && (ld_rd != '0)) busy_d[ld_rd] = 1'b1;
    busy_d[0] = 1'b0;
    resp_err_d = resp_err_q | (lsu_rvalid & fifo_empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rw_q       <= '0;
      wen_q      <= 1'b0;
      busw_q     <= '0;
      busy_q     <= '0;
      resp_err_q <= 1'b0;
    end else begin
      rw_q       <= rw_d;
      wen_q      <= wen_d;
      busw_q     <= busw_d;
      busy_q     <= busy_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign dec_stall = ((|dec_rs1) & busy_q[dec_rs1])
                   | ((|dec_rs2) & busy_q[dec_rs2])
                   | ((|dec_rd)  & busy_q[dec_rd]);
  assign byp_a_en  = wen_q & (rw_q == dec_rs1) & (|dec_rs1);
  assign byp_b_en  = wen_q & (rw_q == dec_rs2) & (|dec_rs2);

  assign Rw       = rw_q;
  assign Wen      = wen_q;
  assign BusW     = busw_q;
  assign resp_err = resp_err_q;

endmodule
